// File: rtl/mrr_pathway_merge.sv
// mrr_pathway_merge
//   Merges NUM_PATHWAYS decode-pathway AXI-streams into one packet-atomic,
//   round-robin arbitrated output stream. Each packet may be prefixed by a tag
//   beat {pad, 8'hA5, pathway, seq}. Packets longer than 2^MAX_PKT_LEN_LOG2
//   beats are truncated (forced tlast), the remainder drained upstream and the
//   sticky overflow_err raised. A separate single-owner arbiter decides which
//   pathway drives the front-end TX enable and counts refused requests.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_tdata/i_tvalid/i_tlast       per-pathway input streams (pathway p in
//                                  slice [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH])
//   i_tready                       per-pathway ready
//   enable_mask                    pathways eligible for a packet grant
//   o_tdata/o_tvalid/o_tlast       merged stream, o_tready downstream ready
//   o_tuser                        pathway index owning the current beat
//   tx_en_in                       per-pathway TX request
//   tx_en_out, tx_owner            TX enable to front-end and its owner
//   tx_collisions                  saturating count of refused TX requests
//   overflow_err                   sticky packet-truncation flag
//   pkt_count                      wrapping count of emitted packets
module mrr_pathway_merge #(
  parameter int NUM_PATHWAYS     = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int IDX_WIDTH        = 2,
  parameter bit TAG_ENABLE       = 1'b1,
  parameter int MAX_PKT_LEN_LOG2 = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  input  logic [NUM_PATHWAYS-1:0]            enable_mask,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic                               o_tvalid,
  output logic                               o_tlast,
  input  logic                               o_tready,
  output logic [IDX_WIDTH-1:0]               o_tuser,
  input  logic [NUM_PATHWAYS-1:0]            tx_en_in,
  output logic                               tx_en_out,
  output logic [IDX_WIDTH-1:0]               tx_owner,
  output logic [15:0]                        tx_collisions,
  output logic                               overflow_err,
  output logic [15:0]                        pkt_count
);

  // Vectors are padded to 2^IDX_WIDTH slots so an IDX_WIDTH index always
  // selects in range; unused slots read as zero.
  localparam int NSLOT  = 1 << IDX_WIDTH;
  localparam int BEAT_W = MAX_PKT_LEN_LOG2 + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((1 << MAX_PKT_LEN_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA, S_DRAIN} state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [4:0] popcount(input logic [NUM_PATHWAYS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NUM_PATHWAYS; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tag_word(input logic [IDX_WIDTH-1:0] g,
                                                     input logic [15:0] s);
    return DATA_WIDTH'({8'hA5, 8'(g), s});
  endfunction

  state_t                state;
  logic [IDX_WIDTH-1:0]  grant;
  logic [IDX_WIDTH-1:0]  last_grant;
  logic [15:0]           seq;
  logic [BEAT_W-1:0]     beat_cnt;

  logic [NSLOT-1:0]      req_pad;
  logic [NSLOT-1:0]      valid_pad;
  logic [NSLOT-1:0]      last_pad;
  logic [NSLOT-1:0]      ready_pad;
  logic [DATA_WIDTH-1:0] data_arr [NSLOT];
  logic                  req_any;
  logic [IDX_WIDTH-1:0]  rr_idx;
  logic                  at_limit;
  logic                  data_hs;

  assign req_pad   = NSLOT'(i_tvalid & enable_mask);
  assign valid_pad = NSLOT'(i_tvalid);
  assign last_pad  = NSLOT'(i_tlast);
  assign at_limit  = (beat_cnt == LAST_BEAT);
  assign data_hs   = (state == S_DATA) && valid_pad[grant] && o_tready;
  assign i_tready  = ready_pad[NUM_PATHWAYS-1:0];

  always_comb begin
    for (int s = 0; s < NSLOT; s++) data_arr[s] = '0;
    for (int p = 0; p < NUM_PATHWAYS; p++) data_arr[p] = i_tdata[DATA_WIDTH*p +: DATA_WIDTH];
  end

  // Round-robin search starting just above the previous grant.
  always_comb begin
    req_any = 1'b0;
    rr_idx  = '0;
    for (int k = 1; k <= NUM_PATHWAYS; k++) begin
      if (!req_any && req_pad[IDX_WIDTH'((int'(last_grant) + k) % NUM_PATHWAYS)]) begin
        req_any = 1'b1;
        rr_idx  = IDX_WIDTH'((int'(last_grant) + k) % NUM_PATHWAYS);
      end
    end
  end

  // Output mux: DATA is a zero-latency pass-through of the granted pathway.
  always_comb begin
    o_tvalid  = 1'b0;
    o_tlast   = 1'b0;
    o_tdata   = '0;
    o_tuser   = '0;
    ready_pad = '0;
    case (state)
      S_TAG: begin
        o_tvalid = 1'b1;
        o_tuser  = grant;
        o_tdata  = tag_word(grant, seq);
      end
      S_DATA: begin
        o_tvalid         = valid_pad[grant];
        o_tlast          = last_pad[grant] | at_limit;
        o_tdata          = data_arr[grant];
        o_tuser          = grant;
        ready_pad[grant] = o_tready;
      end
      S_DRAIN: ready_pad[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      last_grant   <= IDX_WIDTH'(NUM_PATHWAYS - 1);
      seq          <= '0;
      beat_cnt     <= '0;
      pkt_count    <= '0;
      overflow_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            grant      <= rr_idx;
            last_grant <= rr_idx;
            beat_cnt   <= '0;
            state      <= TAG_ENABLE ? S_TAG : S_DATA;
          end
        end
        S_TAG: begin
          if (o_tready) state <= S_DATA;
        end
        S_DATA: begin
          if (data_hs) begin
            if (last_pad[grant]) begin
              pkt_count <= pkt_count + 16'd1;
              seq       <= seq + 16'd1;
              beat_cnt  <= '0;
              state     <= S_IDLE;
            end else if (at_limit) begin
              // Truncate: this beat carries a forced tlast, rest is drained.
              overflow_err <= 1'b1;
              pkt_count    <= pkt_count + 16'd1;
              seq          <= seq + 16'd1;
              beat_cnt     <= '0;
              state        <= S_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (valid_pad[grant] && last_pad[grant]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // TX arbitration. A request that collides is blocked until it drops, so a
  // pathway held high across a release must re-raise to become owner.
  logic                    tx_owned;
  logic [NUM_PATHWAYS-1:0] tx_prev;
  logic [NUM_PATHWAYS-1:0] tx_blocked;
  logic [NUM_PATHWAYS-1:0] tx_rise;
  logic [NUM_PATHWAYS-1:0] tx_elig;
  logic [NUM_PATHWAYS-1:0] tx_collide;
  logic [NSLOT-1:0]        tx_pad;
  logic [NSLOT-1:0]        owner_oh;
  logic [NSLOT-1:0]        pick_oh;
  logic                    tx_pick_any;
  logic [IDX_WIDTH-1:0]    tx_pick;

  assign tx_rise  = tx_en_in & ~tx_prev;
  assign tx_elig  = tx_en_in & ~tx_blocked;
  assign tx_pad   = NSLOT'(tx_en_in);
  assign owner_oh = NSLOT'(1) << tx_owner;
  assign pick_oh  = NSLOT'(1) << tx_pick;

  always_comb begin
    tx_pick_any = 1'b0;
    tx_pick     = '0;
    for (int p = NUM_PATHWAYS - 1; p >= 0; p--) begin
      if (tx_elig[p]) begin
        tx_pick_any = 1'b1;
        tx_pick     = IDX_WIDTH'(p);
      end
    end
  end

  always_comb begin
    tx_collide = '0;
    if (tx_owned)
      tx_collide = tx_rise & ~owner_oh[NUM_PATHWAYS-1:0];
    else if (tx_pick_any)
      tx_collide = tx_rise & tx_elig & ~pick_oh[NUM_PATHWAYS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_owned      <= 1'b0;
      tx_owner      <= '0;
      tx_en_out     <= 1'b0;
      tx_collisions <= '0;
      tx_prev       <= '0;
      tx_blocked    <= '0;
    end else begin
      tx_prev       <= tx_en_in;
      tx_blocked    <= (tx_blocked & tx_en_in) | tx_collide;
      tx_collisions <= sat_add16(tx_collisions, popcount(tx_collide));
      if (tx_owned) begin
        if (tx_pad[tx_owner]) begin
          tx_en_out <= 1'b1;
        end else begin
          tx_owned  <= 1'b0;
          tx_en_out <= 1'b0;
        end
      end else if (tx_pick_any) begin
        tx_owned  <= 1'b1;
        tx_owner  <= tx_pick;
        tx_en_out <= 1'b1;
      end else begin
        tx_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mrr_pathway_merge.sv
// Testbench for mrr_pathway_merge: directed packet scenarios on a 4-pathway,
// tagged instance with 4-beat maximum packets, plus TX arbitration and reset.
module tb_mrr_pathway_merge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] i_tdata = '0;
  logic [3:0]   i_tvalid = '0;
  logic [3:0]   i_tlast = '0;
  logic [3:0]   i_tready;
  logic [3:0]   enable_mask = '0;
  logic [31:0]  o_tdata;
  logic         o_tvalid;
  logic         o_tlast;
  logic         o_tready = 1'b1;
  logic [1:0]   o_tuser;
  logic [3:0]   tx_en_in = '0;
  logic         tx_en_out;
  logic [1:0]   tx_owner;
  logic [15:0]  tx_collisions;
  logic         overflow_err;
  logic [15:0]  pkt_count;

  always #5 clk = ~clk;

  mrr_pathway_merge #(
    .NUM_PATHWAYS(4), .DATA_WIDTH(32), .IDX_WIDTH(2),
    .TAG_ENABLE(1'b1), .MAX_PKT_LEN_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .enable_mask(enable_mask),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready),
    .o_tuser(o_tuser),
    .tx_en_in(tx_en_in), .tx_en_out(tx_en_out), .tx_owner(tx_owner),
    .tx_collisions(tx_collisions), .overflow_err(overflow_err), .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [1:0]  user;
    logic        last;
    logic [31:0] data;
  } beat_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [3:0]  hs;
  beat_t       log_q [$];
  int          log_cyc [$];
  logic [31:0] src_d [4][$];
  logic        src_l [4][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] bt(input logic [1:0] u, input logic l, input logic [31:0] d);
    return {29'd0, u, l, d};
  endfunction

  function automatic logic [63:0] tg(input logic [1:0] u, input logic [15:0] s);
    return bt(u, 1'b0, {8'hA5, 6'd0, u, s});
  endfunction

  task automatic check_log(input string tag, input int i, input logic [63:0] exp);
    logic [63:0] got;
    got = (i < log_q.size()) ? 64'(log_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
    check($sformatf("%s[%0d]", tag, i), got, exp);
  endtask

  task automatic push(input int p, input logic [31:0] d, input logic l);
    src_d[p].push_back(d);
    src_l[p].push_back(l);
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (src_d[p].size() > 0) begin
        i_tvalid[p]          = 1'b1;
        i_tdata[32*p +: 32]  = src_d[p][0];
        i_tlast[p]           = src_l[p][0];
      end else begin
        i_tvalid[p]          = 1'b0;
        i_tdata[32*p +: 32]  = '0;
        i_tlast[p]           = 1'b0;
      end
    end
  endtask

  task automatic sample();
    drive();
    @(negedge clk);
    hs = i_tvalid & i_tready;
    if (o_tvalid && o_tready) begin
      log_q.push_back({o_tuser, o_tlast, o_tdata});
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (hs[p] && src_d[p].size() > 0) begin
        void'(src_d[p].pop_front());
        void'(src_l[p].pop_front());
      end
    end
    drive();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    tx_en_in    = '0;
    o_tready    = 1'b1;
    enable_mask = '0;
    for (int p = 0; p < 4; p++) begin
      src_d[p].delete();
      src_l[p].delete();
    end
    drive();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 64'(o_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(o_tlast), 64'd0);
    check({tag, "_tdata"}, 64'(o_tdata), 64'd0);
    check({tag, "_tuser"}, 64'(o_tuser), 64'd0);
    check({tag, "_itready"}, 64'(i_tready), 64'd0);
    check({tag, "_tx_en_out"}, 64'(tx_en_out), 64'd0);
    check({tag, "_tx_owner"}, 64'(tx_owner), 64'd0);
    check({tag, "_tx_coll"}, 64'(tx_collisions), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_err), 64'd0);
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
  endtask

  initial begin
    int gap;

    // Reset state
    do_reset();
    check_zero("rst");

    // Two simultaneous 3-beat packets on pathways 0 and 2
    enable_mask = 4'hF;
    push(0, 32'h1000_00A0, 1'b0); push(0, 32'h1000_00A1, 1'b0); push(0, 32'h1000_00A2, 1'b1);
    push(2, 32'h1000_00C0, 1'b0); push(2, 32'h1000_00C1, 1'b0); push(2, 32'h1000_00C2, 1'b1);
    repeat (12) cycle();
    check_log("t1", 0, tg(2'd0, 16'd0));
    check_log("t1", 1, bt(2'd0, 1'b0, 32'h1000_00A0));
    check_log("t1", 2, bt(2'd0, 1'b0, 32'h1000_00A1));
    check_log("t1", 3, bt(2'd0, 1'b1, 32'h1000_00A2));
    check_log("t1", 4, tg(2'd2, 16'd1));
    check_log("t1", 5, bt(2'd2, 1'b0, 32'h1000_00C0));
    check_log("t1", 6, bt(2'd2, 1'b0, 32'h1000_00C1));
    check_log("t1", 7, bt(2'd2, 1'b1, 32'h1000_00C2));
    check("t1_log_size", 64'(log_q.size()), 64'd8);
    gap = (log_q.size() >= 5) ? (log_cyc[4] - log_cyc[3]) : -1;
    check("t1_idle_gap", 64'(gap), 64'd2);
    check("t1_pkt_count", 64'(pkt_count), 64'd2);
    check("t1_ovf", 64'(overflow_err), 64'd0);

    // All pathways continuously valid with 1-beat packets: strict rotation
    do_reset();
    enable_mask = 4'hF;
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < 4; p++) push(p, 32'h2000_0000 | 32'(p << 8) | 32'(n), 1'b1);
    repeat (30) cycle();
    for (int k = 0; k < 8; k++) begin
      check_log("t2", 2 * k, tg(2'(k % 4), 16'(k)));
      check_log("t2", 2 * k + 1, bt(2'(k % 4), 1'b1, 32'h2000_0000 | 32'((k % 4) << 8) | 32'(k / 4)));
    end
    check("t2_log_size", 64'(log_q.size()), 64'd16);
    check("t2_pkt_count", 64'(pkt_count), 64'd8);

    // 6-beat packet on p1 with a 4-beat limit, followed by a normal packet
    do_reset();
    enable_mask = 4'hF;
    for (int i = 0; i < 6; i++) push(1, 32'h3000_0000 | 32'(i), (i == 5));
    push(1, 32'h3000_00E0, 1'b1);
    repeat (16) cycle();
    check_log("t3", 0, tg(2'd1, 16'd0));
    check_log("t3", 1, bt(2'd1, 1'b0, 32'h3000_0000));
    check_log("t3", 2, bt(2'd1, 1'b0, 32'h3000_0001));
    check_log("t3", 3, bt(2'd1, 1'b0, 32'h3000_0002));
    check_log("t3", 4, bt(2'd1, 1'b1, 32'h3000_0003));
    check_log("t3", 5, tg(2'd1, 16'd1));
    check_log("t3", 6, bt(2'd1, 1'b1, 32'h3000_00E0));
    check("t3_log_size", 64'(log_q.size()), 64'd7);
    check("t3_ovf", 64'(overflow_err), 64'd1);
    check("t3_pkt_count", 64'(pkt_count), 64'd2);
    check("t3_src_empty", 64'(src_d[1].size()), 64'd0);

    // Downstream ready toggling every cycle; p0 valid but masked off
    do_reset();
    enable_mask = 4'b0100;
    push(0, 32'h4000_00B0, 1'b1);
    for (int i = 0; i < 3; i++) push(2, 32'h4000_0000 | 32'(i), (i == 2));
    for (int i = 0; i < 20; i++) begin
      o_tready = cyc[0];
      sample();
      check("t4_others_rdy", 64'(i_tready & 4'b1011), 64'd0);
      if (o_tvalid && o_tdata[31:24] != 8'hA5)
        check("t4_rdy_mirror", 64'(i_tready), 64'({o_tready, 2'b00}));
      advance();
    end
    o_tready = 1'b1;
    check_log("t4", 0, tg(2'd2, 16'd0));
    check_log("t4", 1, bt(2'd2, 1'b0, 32'h4000_0000));
    check_log("t4", 2, bt(2'd2, 1'b0, 32'h4000_0001));
    check_log("t4", 3, bt(2'd2, 1'b1, 32'h4000_0002));
    check("t4_log_size", 64'(log_q.size()), 64'd4);
    check("t4_p0_untouched", 64'(src_d[0].size()), 64'd1);

    // TX arbitration: p3 owns, p1 collides twice, then must re-raise
    do_reset();
    tx_en_in = 4'b1000; cycle();
    check("t5_own_en", 64'(tx_en_out), 64'd1);
    check("t5_own_idx", 64'(tx_owner), 64'd3);
    tx_en_in = 4'b1010; cycle();
    tx_en_in = 4'b1000; cycle();
    tx_en_in = 4'b1010; cycle();
    check("t5_coll", 64'(tx_collisions), 64'd2);
    check("t5_hold_en", 64'(tx_en_out), 64'd1);
    check("t5_hold_idx", 64'(tx_owner), 64'd3);
    tx_en_in = 4'b0010; cycle();
    check("t5_release_en", 64'(tx_en_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_blocked_en", 64'(tx_en_out), 64'd0);
      check("t5_owner_held", 64'(tx_owner), 64'd3);
    end
    tx_en_in = 4'b0000; cycle();
    tx_en_in = 4'b0010; cycle();
    check("t5_regrant_en", 64'(tx_en_out), 64'd1);
    check("t5_regrant_idx", 64'(tx_owner), 64'd1);
    check("t5_coll_final", 64'(tx_collisions), 64'd2);

    // Reset during the second data beat of a packet
    do_reset();
    enable_mask = 4'hF;
    push(1, 32'h6000_0000, 1'b0); push(1, 32'h6000_0001, 1'b0); push(1, 32'h6000_0002, 1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    enable_mask = 4'b0000;
    sample();
    check("t6_beat2_on_bus", 64'(o_tdata), 64'h6000_0001);
    advance();
    check_zero("t6");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t6_no_grant_valid", 64'(o_tvalid), 64'd0);
      check("t6_no_grant_ready", 64'(i_tready), 64'd0);
      advance();
    end
    check("t6_beat3_pending", 64'(src_d[1].size()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrr_pathway_merge.md
Name: mrr_pathway_merge

Overview:
- Parametrised successor to the per-pathway output fan-out of the MRR gateway header.
- Merges NUM_PATHWAYS independent decode-pathway AXI-streams into one packet-atomic, round-robin-arbitrated stream. Each packet is prefixed with a tag word identifying the pathway and a sequence number.
- Replaces the plain OR of pathway tx_en with single-owner TX arbitration and collision accounting.
- Sits between the per-pathway loopback instances and the host-facing output FIFO.

Parameters:
- NUM_PATHWAYS, 4: number of decode pathways merged (1..16).
- DATA_WIDTH, 32: stream word width; must be >= 32.
- IDX_WIDTH, 2: width of the pathway index; must satisfy 2^IDX_WIDTH >= NUM_PATHWAYS.
- TAG_ENABLE, 1: 1 = emit a tag beat before every packet; 0 = no tag beat.
- MAX_PKT_LEN_LOG2, 10: payload beats allowed per packet = 2^MAX_PKT_LEN_LOG2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_tdata  in  DATA_WIDTH*NUM_PATHWAYS  pathway p occupies slice [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH].
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tlast  in  NUM_PATHWAYS  per-pathway last.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- enable_mask  in  NUM_PATHWAYS  pathways eligible for grant.
- o_tdata  out  DATA_WIDTH  merged data.
- o_tvalid  out  1  merged valid.
- o_tlast  out  1  merged last.
- o_tready  in  1  downstream ready.
- o_tuser  out  IDX_WIDTH  index of the pathway owning the current beat.
- tx_en_in  in  NUM_PATHWAYS  per-pathway TX request.
- tx_en_out  out  1  TX enable to the front-end.
- tx_owner  out  IDX_WIDTH  current TX owner.
- tx_collisions  out  16  saturating count of refused TX requests.
- overflow_err  out  1  sticky: a packet was truncated.
- pkt_count  out  16  wrapping count of emitted packets.

Behaviour:
- Reset, synchronous: all outputs 0, state IDLE, last_grant = NUM_PATHWAYS-1, sequence counter 0, TX unowned.
- Reset mid-packet: the next cycle is IDLE with o_tvalid=0. Any remaining upstream beats are treated as a new packet.

Merge FSM states: IDLE, TAG, DATA, DRAIN.
- IDLE:
  - req = i_tvalid & enable_mask.
  - Grant the first set bit searching upward from last_grant+1, wrapping at NUM_PATHWAYS.
  - Register grant and last_grant in the same cycle.
  - Next state is TAG if TAG_ENABLE, else DATA.
  - No request: stay in IDLE. o_tvalid=0 and i_tready=0 in IDLE.
- TAG:
  - o_tvalid=1, o_tlast=0, o_tuser=grant.
  - o_tdata = {zero pad, 8'hA5, 8'(grant), 16'(seq)}.
  - All i_tready=0.
  - On o_tready, go to DATA.
- DATA:
  - Combinational pass-through, zero latency: o_tdata, o_tvalid, o_tlast from the granted pathway; i_tready[grant]=o_tready; all other i_tready=0.
  - A beat counter increments on each handshake.
  - On a handshake with i_tlast: pkt_count+1, seq+1, clear the beat counter, go to IDLE. The next grant starts in the following cycle, so there is 1 idle cycle between packets.
  - If the handshake beat is number 2^MAX_PKT_LEN_LOG2 and i_tlast=0: force o_tlast=1 on that beat, set overflow_err, pkt_count+1, seq+1, go to DRAIN.
- DRAIN:
  - i_tready[grant]=1, o_tvalid=0; upstream beats are discarded.
  - Leave for IDLE on the handshake carrying i_tlast.
- Mask: enable_mask is sampled only in IDLE. Deasserting the granted bit mid-packet does not abort the packet.
- seq and pkt_count wrap 0xFFFF -> 0. tx_collisions saturates at 0xFFFF.
- overflow_err clears only on rst.

TX arbitration:
- Unowned and any tx_en_in set: the lowest set index becomes owner. tx_en_out=1 from the next cycle.
- Owned: tx_en_out = tx_en_in[owner], registered (1-cycle latency). Ownership is released on the cycle owner's tx_en_in falls; tx_en_out=0 on the following cycle.
- A new owner may be granted in the cycle after release.
- Each rising edge of a non-owner tx_en_in while owned: tx_collisions+1. The request is ignored until it is re-raised after release.
- Simultaneous rising requests while unowned: the lowest index wins. The others count as collisions.
- tx_owner holds its last value while unowned.

Test Plan:
- Pathways 0 and 2 each offer a 3-beat packet simultaneously, TAG_ENABLE=1, o_tready=1 -> output is tag(0,seq0), 3 beats p0, idle cycle, tag(2,seq1), 3 beats p2; o_tuser 0 then 2; pkt_count=2.
- All 4 pathways continuously valid with 1-beat packets -> grant order 0,1,2,3,0; no pathway granted twice before the others.
- MAX_PKT_LEN_LOG2=2, 6-beat packet on p1 -> 4 beats out with o_tlast on beat 4; overflow_err=1; beats 5-6 consumed with o_tvalid=0; next packet starts normally.
- o_tready toggles 1/0 every cycle during DATA -> no beat lost or duplicated; i_tready[grant] mirrors o_tready; non-granted i_tready stay 0.
- tx_en_in[3] high, then tx_en_in[1] rises twice during ownership -> tx_en_out=1, tx_owner=3, tx_collisions=2. After tx_en_in[3] falls, tx_en_out=0 for 1 cycle; p1 is granted only after it re-raises.
- rst asserted during the 2nd beat of a packet -> next cycle all outputs 0 and state IDLE; with enable_mask=0, no grant follows.
